// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: parallel register requests -> ASCII byte stream, one-byte read replies.
// Optional UART_CMD_ADDR_CACHE_EN skips the address bytes when the request hits the last issued address.
module uart_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TX_HOLD        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_read
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(TX_HOLD + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR_HI  = 4'd1;
    localparam logic [3:0] S_ADDR_LO  = 4'd2;
    localparam logic [3:0] S_ADDR_CMD = 4'd3;
    localparam logic [3:0] S_DATA_HI  = 4'd4;
    localparam logic [3:0] S_DATA_LO  = 4'd5;
    localparam logic [3:0] S_DATA_CMD = 4'd6;
    localparam logic [3:0] S_READ_CMD = 4'd7;
    localparam logic [3:0] S_RSP_WAIT = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    logic [3:0]    state;
    logic [TW-1:0] to_cnt;
    logic [HW-1:0] hold_cnt;
    logic          r_write;
    logic [7:0]    r_addr;
    logic [7:0]    r_wdata;
    logic          byte_state;
    logic          tx_fire;
    logic          to_expire;
    logic          cache_hit;

    always_comb begin
        tx_data    = 8'h00;
        byte_state = 1'b1;
        case (state)
            S_ADDR_HI:  tx_data = 8'h30 | {4'h0, r_addr[7:4]};
            S_ADDR_LO:  tx_data = 8'h30 | {4'h0, r_addr[3:0]};
            S_ADDR_CMD: tx_data = 8'h6d;
            S_DATA_HI:  tx_data = 8'h30 | {4'h0, r_wdata[7:4]};
            S_DATA_LO:  tx_data = 8'h30 | {4'h0, r_wdata[3:0]};
            S_DATA_CMD: tx_data = 8'h77;
            S_READ_CMD: tx_data = 8'h72;
            default:    byte_state = 1'b0;
        endcase
    end

    assign tx_fire   = byte_state & tx_ready & (hold_cnt == '0) & ~reset;
    assign tx_write  = tx_fire;
    // Reply bytes are consumed in RSP_WAIT; anywhere else they are stale and drained.
    assign rx_read   = rx_ready & ~reset;
    assign req_ready = (state == S_IDLE) & ~reset;
    assign rsp_valid = (state == S_DONE);
    assign to_expire = (state == S_RSP_WAIT) & ~rx_ready & (to_cnt == TO_LAST);

`ifdef UART_CMD_ADDR_CACHE_EN
    logic [7:0] cache_addr;
    logic       cache_vld;

    assign cache_hit = cache_vld & (cache_addr == req_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld  <= 1'b0;
            cache_addr <= 8'h00;
        end else if (state == S_ADDR_CMD && tx_fire) begin
            cache_vld  <= 1'b1;
            cache_addr <= r_addr;
        end else if (to_expire) begin
            // Responder state is unknown after a lost reply; force a fresh address next time.
            cache_vld  <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            if (tx_fire)
                hold_cnt <= HW'(TX_HOLD);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);

            case (state)
                S_IDLE: if (req_valid) begin
                    r_write <= req_write;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    if (cache_hit) state <= req_write ? S_DATA_HI : S_READ_CMD;
                    else           state <= S_ADDR_HI;
                end
                S_ADDR_HI:  if (tx_fire) state <= S_ADDR_LO;
                S_ADDR_LO:  if (tx_fire) state <= S_ADDR_CMD;
                S_ADDR_CMD: if (tx_fire) state <= r_write ? S_DATA_HI : S_READ_CMD;
                S_DATA_HI:  if (tx_fire) state <= S_DATA_LO;
                S_DATA_LO:  if (tx_fire) state <= S_DATA_CMD;
                S_DATA_CMD: if (tx_fire) begin
                    rsp_timeout <= 1'b0;
                    state       <= S_DONE;
                end
                S_READ_CMD: if (tx_fire) begin
                    to_cnt <= '0;
                    state  <= S_RSP_WAIT;
                end
                S_RSP_WAIT: begin
                    if (rx_ready) begin
                        rsp_data    <= rx_data;
                        rsp_timeout <= 1'b0;
                        state       <= S_DONE;
                    end else if (to_expire) begin
                        rsp_data    <= 8'hff;
                        rsp_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: byte streams, read reply/timeout, stale drain, reset, random tx_ready.
module tb_uart_cmd_master;
    localparam int TO = 100;
    localparam int TH = 2;
`ifdef UART_CMD_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       rsp_valid, rsp_timeout;
    logic [7:0] rsp_data;
    logic [7:0] tx_data;
    logic       tx_write, tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0, rx_read;

    uart_cmd_master #(.TIMEOUT_CYCLES(TO), .TX_HOLD(TH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_read(rx_read)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: logs every transmitted byte with its cycle, counts reads/responses/handshake violations.
    logic [7:0] txq[$];
    int         txc[$];
    int         rdcnt = 0, vcnt = 0, viol = 0;
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            if (tx_write) begin
                txq.push_back(tx_data);
                txc.push_back(cyc);
                if (!tx_ready) viol++;
            end
            if (rx_read) rdcnt++;
            if (rsp_valid) vcnt++;
        end
    end

    int n_chk = 0, n_fail = 0;
    bit rnd = 1'b0;
    int acc_cyc, rsp_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
        if (rnd) tx_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [63:0] pack(input int b, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            if (b + i < txq.size()) v = {v[55:0], txq[b + i]};
        return v;
    endfunction

    function automatic logic [7:0] hx(input logic [3:0] n);
        return 8'h30 | {4'h0, n};
    endfunction

    task automatic encode(input bit w, input logic [7:0] a, input logic [7:0] d, input bit hit,
                          output int len, output logic [63:0] v);
        v = '0; len = 0;
        if (!hit) begin v = {hx(a[7:4]), hx(a[3:0]), 8'h6d}; len = 3; end
        if (w) begin v = {v[39:0], hx(d[7:4]), hx(d[3:0]), 8'h77}; len += 3; end
        else   begin v = {v[55:0], 8'h72}; len += 1; end
    endtask

    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (req_ready) begin acc_cyc = cyc; ok = 1'b1; end
            step();
        end
        req_valid = 1'b0; req_addr = 8'hxx; req_wdata = 8'hxx;
        chk("req_accept", ok, 1'b1);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 400 && txq.size() < n; k++) step();
        chk("tx_count_reached", txq.size() >= n, 1'b1);
    endtask

    task automatic wait_rsp(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            if (rsp_valid) begin rsp_cyc = cyc; ok = 1'b1; end
            else step();
        end
        chk("rsp_seen", ok, 1'b1);
    endtask

    initial begin
        int b, s, v0, rd0, len, lastd;
        bit cvld, hit, rep, w;
        logic [7:0] ca, a, d, rply;
        logic [63:0] ev;

        // Reset state
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_tx_write", tx_write, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_read", rx_read, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        reset = 1'b0;
        step();
        chk("idle_req_ready", req_ready, 1'b1);

        // Write 0x17 <- 0x03
        b = txq.size();
        do_req(1'b1, 8'h17, 8'h03);
        wait_rsp(100);
        chk("wr_len", txq.size() - b, 6);
        chk("wr_bytes", pack(b, 6), 64'h31376d303377);
        chk("wr_first_latency", txc[b] - acc_cyc, 1);
        chk("wr_byte_spacing", txc[b+1] - txc[b], TH + 1);
        chk("wr_rsp_after_w", rsp_cyc - txc[b+5], 1);
        chk("wr_timeout", rsp_timeout, 1'b0);
        chk("wr_rsp_data_held", rsp_data, 8'h00);
        step();
        chk("wr_rsp_one_cycle", rsp_valid, 1'b0);

        // Read 0x22, reply 0x5a 50 cycles after the 'r' strobe
        b = txq.size(); rd0 = rdcnt;
        do_req(1'b0, 8'h22, 8'h00);
        wait_tx(b + 4);
        s = txc[b+3];
        while (cyc < s + 50) step();
        rx_data = 8'h5a; rx_ready = 1'b1;
        #1 chk("rd_rx_read", rx_read, 1'b1);
        step();
        rx_ready = 1'b0;
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_data", rsp_data, 8'h5a);
        chk("rd_timeout", rsp_timeout, 1'b0);
        chk("rd_bytes", pack(b, 4), 64'h32326d72);
        chk("rd_rx_read_once", rdcnt - rd0, 1);

        // Read 0x09 with no reply: timeout, then a late byte drained silently
        step();
        b = txq.size();
        do_req(1'b0, 8'h09, 8'h00);
        wait_tx(b + 4);
        wait_rsp(300);
        chk("to_bytes", pack(b, 4), 64'h30396d72);
        chk("to_latency", rsp_cyc - txc[b+3], TO + 1);
        chk("to_rsp_data", rsp_data, 8'hff);
        chk("to_flag", rsp_timeout, 1'b1);
        step();
        rx_data = 8'h11; rx_ready = 1'b1;
        #1 chk("late_rx_read", rx_read, 1'b1);
        v0 = vcnt;
        step();
        rx_ready = 1'b0;
        repeat (5) step();
        chk("late_no_rsp", vcnt - v0, 0);
        chk("late_idle", req_ready, 1'b1);
        chk("late_rsp_data_held", rsp_data, 8'hff);

        // Two writes to 0x09 (address cache invalid after the timeout)
        b = txq.size();
        do_req(1'b1, 8'h09, 8'ha5);
        wait_rsp(100);
        chk("c1_bytes", pack(b, 6), 64'h30396d3a3577);
        chk("c1_timeout_cleared", rsp_timeout, 1'b0);
        chk("c1_rsp_data_held", rsp_data, 8'hff);
        step();
        b = txq.size();
        do_req(1'b1, 8'h09, 8'h3c);
        wait_rsp(100);
        chk("c2_len", txq.size() - b, CACHE ? 3 : 6);
        chk("c2_bytes", pack(b, txq.size() - b), CACHE ? 64'h333c77 : 64'h30396d333c77);

        // Reset after the 'm' byte of a write
        step();
        b = txq.size();
        do_req(1'b1, 8'h4b, 8'h12);
        wait_tx(b + 3);
        reset = 1'b1;
        step();
        chk("mid_rst_tx_write", tx_write, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0;
        step();
        chk("mid_rst_release_ready", req_ready, 1'b1);
        chk("mid_rst_truncated", txq.size() - b, 3);
        chk("mid_rst_rsp_data", rsp_data, 8'h00);
        b = txq.size();
        do_req(1'b1, 8'h4b, 8'h12);
        wait_rsp(100);
        chk("post_rst_bytes", pack(b, 6), 64'h343b6d313277);

        // Random requests with tx_ready toggling
        reset = 1'b1; step(); reset = 1'b0; step();
        cvld = 1'b0; ca = 8'h00; lastd = 0;
        rnd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 8'h09; 1: a = 8'h17; 2: a = 8'h22; default: a = 8'hc4;
            endcase
            d = 8'($urandom_range(0, 255));
            hit = CACHE && cvld && (ca == a);
            encode(w, a, d, hit, len, ev);
            b = txq.size(); rep = 1'b0; rply = 8'h00; v0 = 0;
            do_req(w, a, d);
            for (int k = 0; k < 600 && v0 == 0; k++) begin
                if (rsp_valid) v0 = 1;
                else begin
                    if (!w && !rep && txq.size() - b >= len) begin
                        rply = 8'($urandom_range(0, 255));
                        rx_data = rply; rx_ready = 1'b1; rep = 1'b1;
                    end else rx_ready = 1'b0;
                    step();
                end
            end
            rx_ready = 1'b0;
            chk("rnd_done", v0, 1);
            chk("rnd_len", txq.size() - b, len);
            chk("rnd_bytes", pack(b, len), ev);
            if (!w) lastd = int'(rply);
            chk("rnd_rsp_data", rsp_data, lastd);
            chk("rnd_timeout", rsp_timeout, 1'b0);
            cvld = 1'b1; ca = a;
            step();
        end
        rnd = 1'b0; tx_ready = 1'b1;
        chk("tx_write_without_ready", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Host-side initiator for the housekeeping UART command protocol: turns parallel register read/write requests into the ASCII byte stream that the housekeeping CPU parses, and collects the CPU's one-byte read replies. It sits between a requesting agent (board controller, companion FPGA, or bench) and a byte-level UART transmit/receive pair, using the same byte handshakes (data/ready/write, data/ready/read) as the existing uart_tx/uart_rx cores.

## Interface

- TIMEOUT_CYCLES, 1000000, clk cycles to wait for a read reply after the 'r' byte is issued; must be ≥1
- TX_HOLD, 2, cycles tx_ready is ignored after each tx_write strobe; must be ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  port address
- req_wdata  in  8  write data, ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read data; 8'hff on timeout; held between pulses
- rsp_timeout  out  1  qualifies rsp_valid; held between pulses
- tx_data  out  8  byte to UART transmitter
- tx_write  out  1  one-cycle strobe, only issued while tx_ready=1
- tx_ready  in  1  transmitter can accept a byte
- rx_data  in  8  byte from UART receiver
- rx_ready  in  1  received byte available
- rx_read  out  1  one-cycle strobe consuming rx_data

## Operation

- Byte encoding: hex digit = 8'h30 | nibble; set-address = 8'h6d ('m'); write = 8'h77 ('w'); read = 8'h72 ('r'). High nibble first.
- Write request: addr_hi, addr_lo, 'm', data_hi, data_lo, 'w' (6 bytes). Read request: addr_hi, addr_lo, 'm', 'r' (4 bytes), then await one reply byte.
- States: IDLE → ADDR_HI → ADDR_LO → ADDR_CMD → (DATA_HI → DATA_LO → DATA_CMD | READ_CMD → RSP_WAIT) → DONE → IDLE.
- Each byte state: drive tx_data, wait for tx_ready=1 and hold counter zero, strobe tx_write one cycle, load hold counter with TX_HOLD, advance.
- req_ready = (state==IDLE) & ~reset. Request fields captured on acceptance; inputs may change afterwards.
- RSP_WAIT: first rx_ready=1 → capture rx_data, strobe rx_read, rsp_timeout=0. Timeout counter (width $clog2(TIMEOUT_CYCLES+1)) cleared on 'r' strobe, increments each cycle; reaching TIMEOUT_CYCLES → rsp_data=8'hff, rsp_timeout=1.
- Stale bytes: in every state except RSP_WAIT, rx_ready=1 causes an rx_read strobe and the byte is discarded (covers late replies after timeout).
- DONE: rsp_valid=1 for one cycle; writes report rsp_timeout=0, rsp_data unchanged.
- Reset values: state IDLE, tx_data 0, tx_write 0, rx_read 0, rsp_valid 0, rsp_data 0, rsp_timeout 0, counters 0, address cache invalid.
- Reset mid-command: outputs return to reset values on the next edge; the truncated byte stream is harmless because the responder forms addresses from the last two digits before a command letter.

## Timing

- Acceptance edge N → earliest tx_write at cycle N+1 (tx_ready held high).
- Back-to-back bytes with tx_ready always high: strobes TX_HOLD+1 cycles apart.
- Write: rsp_valid one cycle after the 'w' strobe, via DONE. Completion means queued to UART, not delivered.
- Read: rx_read and capture in the same cycle rx_ready is first seen in RSP_WAIT; rsp_valid the following cycle.
- Timeout: rsp_valid exactly TIMEOUT_CYCLES+1 cycles after the 'r' strobe if no byte arrives.
- rx_ready and timeout expiry in the same cycle: the byte wins (no timeout).
- Earliest next acceptance: cycle after rsp_valid.

## Configuration

- UART_CMD_ADDR_CACHE_EN defined: block keeps last issued address and a valid flag. A request whose addr equals the cached valid address skips ADDR_HI/ADDR_LO/ADDR_CMD and goes directly to DATA_HI or READ_CMD. Valid is set after each 'm' strobe and cleared on reset and on read timeout.
- Undefined: every request sends the full address sequence; no cache state is present.

## Test plan

- Write addr 8'h17, data 8'h03, tx_ready=1 → tx bytes 31,37,6d,30,33,77; rsp_valid one cycle after the 77 strobe; rsp_timeout=0.
- Read addr 8'h22, reply 8'h5a injected 50 cycles after 72 strobe → tx bytes 32,32,6d,72; rx_read once; rsp_data=8'h5a, rsp_timeout=0.
- Read with no reply, TIMEOUT_CYCLES=100 → rsp_valid at cycle 101 after 72 strobe, rsp_data=8'hff, rsp_timeout=1; late byte 8'h11 then drained in IDLE with no rsp_valid.
- tx_ready toggled randomly, 20 random requests → byte sequence unchanged, never tx_write while tx_ready=0, reply data matches a model.
- With UART_CMD_ADDR_CACHE_EN: two writes to 8'h09 → second emits only 30|d_hi, 30|d_lo, 77; after read timeout, next request to 8'h09 resends 30,39,6d.
- Reset asserted after the 6d byte of a write → next edge tx_write=0, req_ready=1 after release; following write emits full 6-byte sequence.
